// File: rtl/seven_seg_scanner_pkg.sv
// Shared constants and types for the four-digit seven-segment scanner.
// Segment codes are active-high in {g,f,e,d,c,b,a} bit order.
package seven_seg_scanner_pkg;

   localparam int IDX_W      = 2;
   localparam int NUM_DIGITS = 4;
   localparam int CNT_W      = 16;

   localparam logic [6:0] SEG_0    = 7'b0111111;
   localparam logic [6:0] SEG_1    = 7'b0000110;
   localparam logic [6:0] SEG_2    = 7'b1011011;
   localparam logic [6:0] SEG_3    = 7'b1001111;
   localparam logic [6:0] SEG_4    = 7'b1100110;
   localparam logic [6:0] SEG_5    = 7'b1101101;
   localparam logic [6:0] SEG_6    = 7'b1111101;
   localparam logic [6:0] SEG_7    = 7'b0000111;
   localparam logic [6:0] SEG_8    = 7'b1111111;
   localparam logic [6:0] SEG_9    = 7'b1101111;
   localparam logic [6:0] SEG_DASH = 7'b1000000;
   localparam logic [6:0] SEG_OFF  = 7'b0000000;

   typedef logic [IDX_W-1:0] idx_t;

   typedef struct packed {
      logic [15:0] digits;
      logic [3:0]  dp_mask;
   } frame_t;

   function automatic logic [NUM_DIGITS-1:0] idx_onehot(input idx_t idx);
      return 4'b0001 << idx;
   endfunction

endpackage

// File: rtl/seven_seg_scanner_bcd_to_7seg.sv
// Combinational BCD to seven-segment decoder, active-high outputs.
// Non-decimal codes 10-15 show a dash so corrupt data is visible on the panel.
module bcd_to_7seg
   import seven_seg_scanner_pkg::*;
(
   input  logic [3:0] bcd_i,
   output logic [6:0] seg_o
);

   always_comb begin
      seg_o = SEG_DASH;
      case (bcd_i)
         4'd0:    seg_o = SEG_0;
         4'd1:    seg_o = SEG_1;
         4'd2:    seg_o = SEG_2;
         4'd3:    seg_o = SEG_3;
         4'd4:    seg_o = SEG_4;
         4'd5:    seg_o = SEG_5;
         4'd6:    seg_o = SEG_6;
         4'd7:    seg_o = SEG_7;
         4'd8:    seg_o = SEG_8;
         4'd9:    seg_o = SEG_9;
         default: seg_o = SEG_DASH;
      endcase
   end

endmodule

// File: rtl/seven_seg_scanner.sv
// Time-multiplexed driver for a four-digit seven-segment display with
// frame-synchronous updates, leading-zero blanking and anti-ghost blanking.
module seven_seg_scanner
   import seven_seg_scanner_pkg::*;
#(
   parameter int unsigned DIV        = 1000,
   parameter bit          ACTIVE_LOW = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        load,
   input  logic [15:0] digits,
   input  logic [3:0]  dp_mask,
   input  logic        blank_lz,
   output logic [6:0]  seg,
   output logic        dp,
   output logic [3:0]  an,
   output logic        frame_done
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);
   localparam idx_t             IDX_ONE  = idx_t'(1);
   localparam idx_t             IDX_LAST = '1;
   localparam logic             POL      = ACTIVE_LOW;

   logic [CNT_W-1:0] cnt_q, cnt_d;
   idx_t             idx_q, idx_d;
   frame_t           hold_q, hold_d;
   frame_t           disp_q, disp_d;
   logic             pend_q, pend_d;

   logic [6:0]       seg_q, seg_d;
   logic             dp_q, dp_d;
   logic [3:0]       an_q, an_d;

   logic             tick;
   logic             wrap;
   logic [3:0]       cur_bcd;
   logic [6:0]       dec_seg;
   logic             lz3, lz2, lz1;
   logic             blank;

   assign tick = (cnt_q == CNT_LAST);
   assign wrap = tick && (idx_q == IDX_LAST);

   // Prescaler, scan index and the holding/display double buffer
   always_comb begin
      cnt_d  = tick ? '0 : cnt_q + CNT_W'(1);
      idx_d  = tick ? idx_q + IDX_ONE : idx_q;
      hold_d = hold_q;
      disp_d = disp_q;
      pend_d = pend_q;
      if (wrap && pend_q) begin
         disp_d = hold_q;
         pend_d = 1'b0;
      end
      // A load on the wrap tick still lands in the holding register and stays pending.
      if (load) begin
         hold_d.digits  = digits;
         hold_d.dp_mask = dp_mask;
         pend_d         = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q  <= '0;
         idx_q  <= '0;
         hold_q <= '0;
         disp_q <= '0;
         pend_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         idx_q  <= idx_d;
         hold_q <= hold_d;
         disp_q <= disp_d;
         pend_q <= pend_d;
      end
   end

   // Digit mux, decode and leading-zero detection
   assign cur_bcd = disp_q.digits[{idx_q, 2'b00} +: 4];

   bcd_to_7seg u_dec (
      .bcd_i (cur_bcd),
      .seg_o (dec_seg)
   );

   assign lz3 = (disp_q.digits[15:12] == 4'd0);
   assign lz2 = lz3 && (disp_q.digits[11:8] == 4'd0);
   assign lz1 = lz2 && (disp_q.digits[7:4] == 4'd0);

   always_comb begin
      blank = 1'b0;
      case (idx_q)
         2'd3:    blank = blank_lz && lz3;
         2'd2:    blank = blank_lz && lz2;
         2'd1:    blank = blank_lz && lz1;
         default: blank = 1'b0;
      endcase
   end

   // Output stage: the tick cycle produces an all-dark cycle as the index moves on
   always_comb begin
      seg_d = SEG_OFF;
      dp_d  = 1'b0;
      an_d  = '0;
      if (!tick) begin
         an_d = idx_onehot(idx_q);
         if (!blank) begin
            seg_d = dec_seg;
            dp_d  = disp_q.dp_mask[idx_q];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         seg_q <= {7{POL}};
         dp_q  <= POL;
         an_q  <= {4{POL}};
      end else begin
         seg_q <= seg_d ^ {7{POL}};
         dp_q  <= dp_d ^ POL;
         an_q  <= an_d ^ {4{POL}};
      end
   end

   assign seg        = seg_q;
   assign dp         = dp_q;
   assign an         = an_q;
   assign frame_done = wrap && !rst;

endmodule
